// File: rtl/id_regfile_linkq_pkg.sv
// Shared definitions for the decode-stage register file with link queue.
// Holds default widths, the link register index, the default-shape queue
// entry type and helpers that size and seed the per-entry age counter.
package id_regfile_linkq_pkg;
  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int LINK_REG_DEF   = 31;
  localparam int LINK_DEPTH_DEF = 2;
  localparam int PIPE_DIST_DEF  = 3;
  localparam int AGE_W_DEF      = 2;

  // Queue entry for the default configuration: {data, age}.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [AGE_W_DEF-1:0]  age;
  } link_entry_t;

  // The stored age already accounts for the accept cycle, so the largest
  // stored value is PIPE_DIST-1.
  function automatic int age_w(input int pipe_dist);
    return (pipe_dist < 3) ? 1 : $clog2(pipe_dist);
  endfunction

  function automatic int age_init(input int pipe_dist);
    return (pipe_dist > 0) ? pipe_dist - 1 : 0;
  endfunction
endpackage

// File: rtl/id_regfile_linkq_if.sv
// Bus between ID and the register file: WB write port, JAL link request,
// read ports and queue status.
//   master: drives wb_*, link_valid/link_data, rd_addr
//   slave : drives link_ready, rd_data, link_count, ovf_err
interface id_regfile_linkq_if
  import id_regfile_linkq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NUM_RD     = 2,
  parameter int LINK_DEPTH = LINK_DEPTH_DEF
);
  localparam int CNT_W = $clog2(LINK_DEPTH + 1);

  logic                     wb_we;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     link_valid;
  logic [DATA_W-1:0]        link_data;
  logic                     link_ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]         link_count;
  logic                     ovf_err;

  modport master (output wb_we, wb_addr, wb_data, link_valid, link_data, rd_addr,
                  input  link_ready, rd_data, link_count, ovf_err);
  modport slave  (input  wb_we, wb_addr, wb_data, link_valid, link_data, rd_addr,
                  output link_ready, rd_data, link_count, ovf_err);
endinterface

// File: rtl/id_regfile_linkq_linkq.sv
// Age-tagged FIFO of pending link-register writes.
// Ports: clk/rst; wb_we_i (WB owns the write port), kill_i (WB targets the
// link register); link_valid_i/link_data_i/link_ready_o/accept_o request
// side; head_data_o/pop_o drain side; count_o; young/old bypass hits;
// ovf_err_o sticky overflow flag.
module id_link_queue
  import id_regfile_linkq_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int LINK_DEPTH = LINK_DEPTH_DEF,
  parameter  int PIPE_DIST  = PIPE_DIST_DEF,
  localparam int CNT_W      = $clog2(LINK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we_i,
  input  logic              kill_i,
  input  logic              link_valid_i,
  input  logic [DATA_W-1:0] link_data_i,
  output logic              link_ready_o,
  output logic              accept_o,
  output logic              pop_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              young_hit_o,
  output logic [DATA_W-1:0] young_data_o,
  output logic              old_hit_o,
  output logic [DATA_W-1:0] old_data_o,
  output logic              ovf_err_o
);
  localparam int AGE_W = age_w(PIPE_DIST);
  localparam logic [AGE_W-1:0] AGE_INIT = AGE_W'(age_init(PIPE_DIST));

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AGE_W-1:0]  age;
  } entry_t;

  // Index 0 is the head (oldest). Ages never increase toward the head, so
  // age==0 entries always form a head-side prefix.
  entry_t           ent_q [LINK_DEPTH];
  entry_t           ent_d [LINK_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d, pop_n;
  logic             ovf_q, ovf_d;
  logic             drain, ready, accept;

  always_comb begin
    drain  = !wb_we_i && (cnt_q != '0);
    ready  = (cnt_q < CNT_W'(LINK_DEPTH)) || drain;
    accept = link_valid_i && ready;
    ovf_d  = ovf_q || (link_valid_i && !ready);
    pop_n  = '0;
    if (drain) pop_n = CNT_W'(1);
    else if (kill_i)
      for (int i = 0; i < LINK_DEPTH; i++)
        if (CNT_W'(i) < cnt_q && ent_q[i].age == '0) pop_n = pop_n + CNT_W'(1);
    // Compact by pop_n, age every surviving entry, append the new one.
    for (int i = 0; i < LINK_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      for (int j = i; j < LINK_DEPTH; j++)
        if (j == i + int'(pop_n)) begin
          ent_d[i].data = ent_q[j].data;
          ent_d[i].age  = (ent_q[j].age == '0) ? '0 : ent_q[j].age - AGE_W'(1);
        end
      if (accept && CNT_W'(i) == cnt_q - pop_n) begin
        ent_d[i].data = link_data_i;
        ent_d[i].age  = AGE_INIT;
      end
    end
    cnt_d = cnt_q - pop_n + CNT_W'(accept);
  end

  // Youngest valid entry of each age class; later index wins.
  always_comb begin
    young_hit_o  = 1'b0;
    young_data_o = '0;
    old_hit_o    = 1'b0;
    old_data_o   = '0;
    for (int i = 0; i < LINK_DEPTH; i++)
      if (CNT_W'(i) < cnt_q) begin
        if (ent_q[i].age != '0) begin
          young_hit_o  = 1'b1;
          young_data_o = ent_q[i].data;
        end else begin
          old_hit_o  = 1'b1;
          old_data_o = ent_q[i].data;
        end
      end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < LINK_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < LINK_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign link_ready_o = ready;
  assign accept_o     = accept;
  assign pop_o        = drain;
  assign head_data_o  = ent_q[0].data;
  assign count_o      = cnt_q;
  assign ovf_err_o    = ovf_q;
endmodule

// File: rtl/id_regfile_linkq.sv
// Decode-stage register file: 2**ADDR_W registers, NUM_RD combinational
// read ports with write-through bypass, one WB write port and a queue of
// pending JAL link writes resolved in program order against WB.
// Ports: clk, rst (sync, active low), bus (slave side of id_regfile_linkq_if).
module id_regfile_linkq
  import id_regfile_linkq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NUM_RD     = 2,
  parameter int LINK_REG   = LINK_REG_DEF,
  parameter int LINK_DEPTH = LINK_DEPTH_DEF,
  parameter int PIPE_DIST  = PIPE_DIST_DEF
) (
  input logic               clk,
  input logic               rst,
  id_regfile_linkq_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0]              regs_q [NREG];
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_pk;
  logic                           kill, accept, pop;
  logic                           young_hit, old_hit;
  logic [DATA_W-1:0]              head_data, young_data, old_data;

  assign kill = bus.wb_we && (bus.wb_addr == LINK_A);

  id_link_queue #(
    .DATA_W(DATA_W), .LINK_DEPTH(LINK_DEPTH), .PIPE_DIST(PIPE_DIST)
  ) u_linkq (
    .clk(clk), .rst(rst),
    .wb_we_i(bus.wb_we), .kill_i(kill),
    .link_valid_i(bus.link_valid), .link_data_i(bus.link_data),
    .link_ready_o(bus.link_ready), .accept_o(accept),
    .pop_o(pop), .head_data_o(head_data), .count_o(bus.link_count),
    .young_hit_o(young_hit), .young_data_o(young_data),
    .old_hit_o(old_hit), .old_data_o(old_data),
    .ovf_err_o(bus.ovf_err)
  );

  // WB owns the write port; the queue head drains only on idle WB cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (bus.wb_we) begin
      if (bus.wb_addr != '0) regs_q[bus.wb_addr] <= bus.wb_data;
    end else if (pop && LINK_A != '0) begin
      regs_q[LINK_A] <= head_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    logic              is_link;
    assign a       = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign is_link = (a == LINK_A);
    // Young entries (age>0) outrank a concurrent WB write; old ones do not.
    always_comb begin
      if (a == '0)                             v = '0;
      else if (is_link && accept)              v = bus.link_data;
      else if (is_link && young_hit)           v = young_data;
      else if (bus.wb_we && bus.wb_addr == a)  v = bus.wb_data;
      else if (is_link && old_hit)             v = old_data;
      else                                     v = regs_q[a];
    end
    assign rd_pk[k] = v;
  end

  assign bus.rd_data = rd_pk;
endmodule

// File: tb/tb_id_regfile_linkq.sv
module tb_id_regfile_linkq;
  localparam int DW = 32, AW = 5, NR = 2, LD = 2, PD = 3;
  localparam int S_RD0 = 0, S_RD1 = 1, S_CNT = 2, S_OVF = 3, S_RDY = 4;

  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_regfile_linkq_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .LINK_DEPTH(LD)) bus ();

  id_regfile_linkq #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .LINK_REG(31), .LINK_DEPTH(LD), .PIPE_DIST(PD)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ncyc    = 0;
  bit   done    = 1'b0;

  task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic lv, input logic [31:0] ld, input logic [4:0] a0, input logic [4:0] a1);
    @(posedge clk);
    #1;
    rst            = r;
    bus.wb_we      = we;
    bus.wb_addr    = wa;
    bus.wb_data    = wd;
    bus.link_valid = lv;
    bus.link_data  = ld;
    bus.rd_addr    = {a1, a0};
  endtask

  task automatic want(input string n, input int sel, input logic [31:0] v);
    sb.push_back('{n, sel, v});
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    ncyc++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        S_RD0:   act = bus.rd_data[31:0];
        S_RD1:   act = bus.rd_data[63:32];
        S_CNT:   act = 32'(bus.link_count);
        S_OVF:   act = 32'(bus.ovf_err);
        default: act = 32'(bus.link_ready);
      endcase
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
      end
    end
    if (!done && ncyc > 1000) begin
      n_fail++;
      $display("FAIL timeout: got %0d cycles, expected under 1000", ncyc);
      done = 1'b1;
    end
    if (done) begin
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    rst = 1'b0;
    bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.link_valid = 0; bus.link_data = 0; bus.rd_addr = 0;

    // Reset clears the array and queue state.
    step(1, 1, 5, 32'h1234, 0, 0, 5, 0); want("wb_bypass_r5", S_RD0, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    step(1, 0, 0, 0, 0, 0, 5, 0);
    want("rst_r5", S_RD0, 0); want("rst_cnt", S_CNT, 0);
    want("rst_ovf", S_OVF, 0); want("rst_ready", S_RDY, 1);

    // Write-through bypass, then array read.
    step(1, 1, 7, 32'hAAAA_0000, 0, 0, 7, 7);
    want("byp_p1", S_RD1, 32'hAAAA_0000); want("byp_p0_same", S_RD0, 32'hAAAA_0000);
    step(1, 0, 0, 0, 0, 0, 0, 7); want("arr_r7", S_RD1, 32'hAAAA_0000);

    // Register 0 ignores writes.
    step(1, 1, 0, 32'hDEAD, 0, 0, 0, 0); want("r0_byp", S_RD0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);        want("r0_arr", S_RD0, 0);

    // Queueing and draining.
    step(1, 1, 3, 32'h33, 1, 32'h400, 31, 3);
    want("q_t0_r31", S_RD0, 32'h400); want("q_t0_r3", S_RD1, 32'h33);
    want("q_t0_rdy", S_RDY, 1); want("q_t0_cnt", S_CNT, 0);
    step(1, 1, 3, 32'h33, 0, 0, 31, 0); want("q_t1_cnt", S_CNT, 1); want("q_t1_r31", S_RD0, 32'h400);
    step(1, 1, 3, 32'h33, 0, 0, 31, 0); want("q_t2_cnt", S_CNT, 1); want("q_t2_r31", S_RD0, 32'h400);
    step(1, 0, 0, 0, 0, 0, 31, 0);      want("q_t3_cnt", S_CNT, 1); want("q_t3_r31", S_RD0, 32'h400);
    step(1, 0, 0, 0, 0, 0, 31, 0);      want("q_t4_cnt", S_CNT, 0); want("q_t4_r31", S_RD0, 32'h400);

    // WB older than a young link entry: link wins.
    step(1, 0, 0, 0, 1, 32'h800, 31, 0);  want("old_t0_r31", S_RD0, 32'h800);
    step(1, 1, 31, 32'h55, 0, 0, 31, 0);  want("old_t1_r31", S_RD0, 32'h800); want("old_t1_cnt", S_CNT, 1);
    step(1, 0, 0, 0, 0, 0, 31, 0);        want("old_t2_r31", S_RD0, 32'h800);
    step(1, 0, 0, 0, 0, 0, 31, 0);        want("old_t3_r31", S_RD0, 32'h800); want("old_t3_cnt", S_CNT, 0);

    // WB younger than an aged-out entry: entry killed.
    step(1, 1, 3, 1, 1, 32'h880, 31, 0);  want("yng_t0_r31", S_RD0, 32'h880);
    step(1, 1, 3, 1, 0, 0, 31, 0);        want("yng_t1_r31", S_RD0, 32'h880); want("yng_t1_cnt", S_CNT, 1);
    step(1, 1, 3, 1, 0, 0, 31, 0);        want("yng_t2_r31", S_RD0, 32'h880);
    step(1, 1, 31, 32'h99, 0, 0, 31, 0);  want("yng_t3_r31", S_RD0, 32'h99); want("yng_t3_cnt", S_CNT, 1);
    step(1, 0, 0, 0, 0, 0, 31, 0);        want("yng_t4_r31", S_RD0, 32'h99); want("yng_t4_cnt", S_CNT, 0);

    // Overflow with WB holding the port.
    step(1, 1, 3, 1, 1, 32'hA1, 31, 0);   want("ovf_t0_rdy", S_RDY, 1);
    step(1, 1, 3, 1, 1, 32'hA2, 31, 0);   want("ovf_t1_rdy", S_RDY, 1); want("ovf_t1_cnt", S_CNT, 1);
    step(1, 1, 3, 1, 1, 32'hA3, 31, 0);
    want("ovf_t2_rdy", S_RDY, 0); want("ovf_t2_cnt", S_CNT, 2);
    want("ovf_t2_flag", S_OVF, 0); want("ovf_t2_r31", S_RD0, 32'hA2);
    step(1, 1, 3, 1, 0, 0, 31, 0);        want("ovf_t3_flag", S_OVF, 1); want("ovf_t3_cnt", S_CNT, 2);
    step(1, 0, 0, 0, 0, 0, 31, 0);        want("ovf_t4_r31", S_RD0, 32'hA2); want("ovf_t4_cnt", S_CNT, 2);
    step(1, 0, 0, 0, 0, 0, 31, 0);        want("ovf_t5_cnt", S_CNT, 1);
    step(1, 0, 0, 0, 0, 0, 31, 0);
    want("ovf_t6_cnt", S_CNT, 0); want("ovf_t6_r31", S_RD0, 32'hA2); want("ovf_sticky", S_OVF, 1);

    // Accept while full and draining in the same cycle.
    step(1, 1, 3, 1, 1, 32'hB1, 31, 0);
    step(1, 1, 3, 1, 1, 32'hB2, 31, 0);
    step(1, 0, 0, 0, 1, 32'hB3, 31, 0);   want("fd_t2_rdy", S_RDY, 1); want("fd_t2_cnt", S_CNT, 2);
    step(1, 1, 3, 1, 0, 0, 31, 0);        want("fd_t3_cnt", S_CNT, 2); want("fd_t3_r31", S_RD0, 32'hB3);
    step(1, 0, 0, 0, 0, 0, 31, 0);        want("fd_t4_cnt", S_CNT, 2);
    step(1, 0, 0, 0, 0, 0, 31, 0);        want("fd_t5_cnt", S_CNT, 1);
    step(1, 0, 0, 0, 0, 0, 31, 0);        want("fd_t6_cnt", S_CNT, 0); want("fd_t6_r31", S_RD0, 32'hB3);

    // Reset with a queued link discards it.
    step(1, 1, 3, 1, 1, 32'hC1, 31, 0);
    step(0, 0, 0, 0, 0, 0, 31, 0);
    step(1, 0, 0, 0, 0, 0, 31, 0);
    want("mrst_cnt", S_CNT, 0); want("mrst_ovf", S_OVF, 0); want("mrst_r31", S_RD0, 0);
    done = 1'b1;
  end
endmodule
